// File: rtl/tdm_tx_converter_pkg.sv
// Shared sizing constants for the STM->DT TDM transmit converter.
package converter_pkg;

  localparam int unsigned NUM_BYTE_IN_BUFFER = 16;
  localparam int unsigned SLOT_BITS          = 32;
  localparam int unsigned BUF_BITS           = 8 * NUM_BYTE_IN_BUFFER;
  localparam int unsigned FRAMES             = BUF_BITS / SLOT_BITS;

  localparam logic IDLE_BIT = 1'b1;

  localparam int unsigned IDX_W   = $clog2(BUF_BITS);
  localparam int unsigned CNT_W   = $clog2(2 * SLOT_BITS + 1);
  localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  typedef logic [BUF_BITS-1:0] buf_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [CNT_W-1:0]    c4cnt_t;
  typedef logic [FRAME_W-1:0]  frame_t;

endpackage

// File: rtl/tdm_tx_converter_if.sv
// TDM line and STM serial-load signals of the transmit converter.
interface tdm_tx_converter_if;

  logic f0;
  logic c4;
  logic clk_from_stm;
  logic data_from_stm;
  logic data_to_dt;
  logic tx_req;
  logic underrun;
  logic overflow;

  modport master (
    output f0, c4, clk_from_stm, data_from_stm,
    input  data_to_dt, tx_req, underrun, overflow
  );

  modport slave (
    input  f0, c4, clk_from_stm, data_from_stm,
    output data_to_dt, tx_req, underrun, overflow
  );

endinterface

// File: rtl/tdm_tx_converter_edge_sync.sv
// 2-FF synchroniser with a registered rising-edge pulse (3 clk50 pin-to-pulse).
module edge_sync (
  input  logic clk50,
  input  logic reset_out_rg,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk50) begin
    if (!reset_out_rg) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/tdm_tx_converter.sv
// Double-buffered STM-to-TDM serialiser, single clk50 domain.
// CONVERTER_TX_UNDERRUN_REPEAT_EN: on underrun retransmit the previous buffer instead of idle.
module tdm_tx_converter
  import converter_pkg::*;
(
  input  logic                clk50,
  input  logic                reset_out_rg,
  tdm_tx_converter_if.slave   bus
);

  localparam c4cnt_t CNT_END    = CNT_W'(2 * SLOT_BITS);
  localparam c4cnt_t CNT_LAST   = CNT_W'(2 * SLOT_BITS - 2);
  localparam idx_t   LOAD_LAST  = IDX_W'(BUF_BITS - 1);
  localparam frame_t FRAME_LAST = FRAME_W'(FRAMES - 1);

  logic   [1:0] f0_pipe, data_pipe;
  logic         f0_s, stm_data;
  logic         c4_rise, stm_rise;

  logic         data_q, tx_req_q, underrun_q, overflow_q;
  buf_t         load_buf, txbuf;
  idx_t         load_cnt;
  logic         load_full;
  frame_t       frame;
  c4cnt_t       c4cnt;

  logic         n_data, n_tx_req, n_underrun, n_overflow;
  buf_t         n_load_buf, n_txbuf;
  idx_t         n_load_cnt;
  logic         n_load_full;
  frame_t       n_frame;
  c4cnt_t       n_c4cnt;

  idx_t         tx_idx, lb_idx;
  logic         swap;

  edge_sync u_c4_sync (
    .clk50        (clk50),
    .reset_out_rg (reset_out_rg),
    .din          (bus.c4),
    .rise         (c4_rise)
  );

  edge_sync u_stm_sync (
    .clk50        (clk50),
    .reset_out_rg (reset_out_rg),
    .din          (bus.clk_from_stm),
    .rise         (stm_rise)
  );

  assign f0_s     = f0_pipe[1];
  assign stm_data = data_pipe[1];

  assign tx_idx = IDX_W'(32'(frame) * SLOT_BITS + 32'(c4cnt[CNT_W-1:1]));
  assign lb_idx = LOAD_LAST - load_cnt;
  assign swap   = c4_rise && f0_s && (c4cnt == CNT_LAST) && (frame == FRAME_LAST);

  always_comb begin
    n_data      = data_q;
    n_tx_req    = tx_req_q;
    n_underrun  = underrun_q;
    n_overflow  = overflow_q;
    n_load_buf  = load_buf;
    n_load_cnt  = load_cnt;
    n_load_full = load_full;
    n_txbuf     = txbuf;
    n_frame     = frame;
    n_c4cnt     = c4cnt;

    if (stm_rise) begin
      if (load_full) begin
        n_overflow = 1'b1;
      end else begin
        n_load_buf[lb_idx] = stm_data;
        if (load_cnt == '0)
          n_tx_req = 1'b0;
        if (load_cnt == LOAD_LAST) begin
          n_load_full = 1'b1;
          n_load_cnt  = '0;
        end else begin
          n_load_cnt = load_cnt + 1'b1;
        end
      end
    end

    if (c4_rise) begin
      if (!f0_s) begin
        n_c4cnt = '0;
        n_data  = IDLE_BIT;
      end else begin
        if (!c4cnt[0] && (c4cnt < CNT_END))
          n_data = txbuf[tx_idx];
        else if (c4cnt == CNT_END)
          n_data = IDLE_BIT;
        if (c4cnt != CNT_END)
          n_c4cnt = c4cnt + 1'b1;
        if (c4cnt == CNT_LAST)
          n_frame = (frame == FRAME_LAST) ? '0 : frame + 1'b1;
      end
    end

    // Evaluated after the load path so a coincident STM bit (load_full still 1) is dropped.
    if (swap) begin
      if (load_full) begin
        n_txbuf     = load_buf;
        n_load_full = 1'b0;
        n_tx_req    = 1'b1;
      end else begin
        n_underrun = 1'b1;
`ifdef CONVERTER_TX_UNDERRUN_REPEAT_EN
        n_txbuf = txbuf;
`else
        n_txbuf = {BUF_BITS{IDLE_BIT}};
`endif
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (!reset_out_rg) begin
      f0_pipe    <= '0;
      data_pipe  <= '0;
      data_q     <= IDLE_BIT;
      tx_req_q   <= 1'b1;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      load_buf   <= '0;
      load_cnt   <= '0;
      load_full  <= 1'b0;
      txbuf      <= {BUF_BITS{IDLE_BIT}};
      frame      <= '0;
      c4cnt      <= '0;
    end else begin
      f0_pipe    <= {f0_pipe[0], bus.f0};
      data_pipe  <= {data_pipe[0], bus.data_from_stm};
      data_q     <= n_data;
      tx_req_q   <= n_tx_req;
      underrun_q <= n_underrun;
      overflow_q <= n_overflow;
      load_buf   <= n_load_buf;
      load_cnt   <= n_load_cnt;
      load_full  <= n_load_full;
      txbuf      <= n_txbuf;
      frame      <= n_frame;
      c4cnt      <= n_c4cnt;
    end
  end

  assign bus.data_to_dt = data_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.underrun   = underrun_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_tdm_tx_converter.sv
// Directed-sequence bench with random buffer contents and a transaction-level line model.
module tb_tdm_tx_converter;
  import converter_pkg::*;

  logic clk50 = 1'b0;
  logic rst_n;

  tdm_tx_converter_if bus ();

  tdm_tx_converter dut (
    .clk50        (clk50),
    .reset_out_rg (rst_n),
    .bus          (bus)
  );

  always #5 clk50 = ~clk50;

  int checks = 0;
  int errors = 0;

  // Model: bits accepted from the STM in arrival order, the buffer on the wire, line state.
  bit                  m_rx[$];
  logic [BUF_BITS-1:0] m_tx;
  int                  m_frame;
  logic                m_tx_req, m_under, m_over, m_line;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_rx.delete();
    m_tx     = '1;
    m_frame  = 0;
    m_tx_req = 1'b1;
    m_under  = 1'b0;
    m_over   = 1'b0;
    m_line   = 1'b1;
  endfunction

  function automatic void m_stm(input bit b);
    if (m_rx.size() == BUF_BITS) begin
      m_over = 1'b1;
    end else begin
      m_rx.push_back(b);
      m_tx_req = 1'b0;
    end
  endfunction

  // First STM bit sits at the buffer MSB; slot bits leave in ascending index order.
  function automatic void m_boundary();
    if (m_rx.size() == BUF_BITS) begin
      for (int i = 0; i < BUF_BITS; i++)
        m_tx[i] = m_rx[BUF_BITS-1-i];
      m_rx.delete();
      m_tx_req = 1'b1;
    end else begin
      m_under = 1'b1;
`ifndef CONVERTER_TX_UNDERRUN_REPEAT_EN
      m_tx = '1;
`endif
    end
  endfunction

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.f0            = 1'b0;
    bus.c4            = 1'b0;
    bus.clk_from_stm  = 1'b0;
    bus.data_from_stm = 1'b0;
    wait_clk(4);
    m_reset();
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  task automatic stm_bit(input bit b);
    bus.data_from_stm = b;
    wait_clk(2);
    bus.clk_from_stm = 1'b1;
    wait_clk(4);
    bus.clk_from_stm = 1'b0;
    wait_clk(3);
    m_stm(b);
  endtask

  task automatic load_buffer(input logic [BUF_BITS-1:0] v);
    for (int i = 0; i < BUF_BITS; i++) begin
      stm_bit(v[BUF_BITS-1-i]);
      if (i == 0)
        chk("tx_req_after_first_bit", bus.tx_req, m_tx_req);
    end
    chk("tx_req_after_load", bus.tx_req, m_tx_req);
  endtask

  task automatic extra_bits(input int n);
    for (int i = 0; i < n; i++)
      stm_bit(1'($urandom));
  endtask

  // One f0 window of nrise c4 rises; optionally an STM edge coincides with the slot's last bit.
  task automatic window(input int nrise, input bit collide);
    bit cbit;
    cbit   = 1'($urandom);
    bus.f0 = 1'b1;
    wait_clk(4);
    for (int k = 0; k < nrise; k++) begin
      if (collide && k == 2*SLOT_BITS-2) begin
        bus.data_from_stm = cbit;
        wait_clk(2);
      end
      bus.c4 = 1'b1;
      if (collide && k == 2*SLOT_BITS-2)
        bus.clk_from_stm = 1'b1;
      if (k < 2*SLOT_BITS && (k % 2) == 0)
        m_line = m_tx[m_frame*SLOT_BITS + k/2];
      else if (k >= 2*SLOT_BITS)
        m_line = IDLE_BIT;
      wait_clk(5);
      chk($sformatf("slot_bit f%0d k%0d", m_frame, k), bus.data_to_dt, m_line);
      if (k == 2*SLOT_BITS-2) begin
        if (collide)
          m_stm(cbit);
        if (m_frame == FRAMES-1) begin
          m_frame = 0;
          m_boundary();
        end else begin
          m_frame++;
        end
      end
      bus.c4           = 1'b0;
      bus.clk_from_stm = 1'b0;
      wait_clk(4);
    end
    bus.f0 = 1'b0;
    wait_clk(4);
    for (int k = 0; k < 2; k++) begin
      bus.c4 = 1'b1;
      m_line = IDLE_BIT;
      wait_clk(5);
      chk("idle_while_f0_low", bus.data_to_dt, m_line);
      bus.c4 = 1'b0;
      wait_clk(4);
    end
    chk("tx_req", bus.tx_req, m_tx_req);
    chk("underrun", bus.underrun, m_under);
    chk("overflow", bus.overflow, m_over);
  endtask

  task automatic full_frames(input int n);
    for (int i = 0; i < n; i++)
      window(2*SLOT_BITS + 1, 1'b0);
  endtask

  function automatic logic [BUF_BITS-1:0] rand_buf();
    logic [BUF_BITS-1:0] v;
    for (int i = 0; i < BUF_BITS/32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [BUF_BITS-1:0] va, vb;

    // Reset state and idle transmission
    do_reset();
    chk("reset_data_to_dt", bus.data_to_dt, 1'b1);
    chk("reset_tx_req", bus.tx_req, 1'b1);
    chk("reset_underrun", bus.underrun, 1'b0);
    chk("reset_overflow", bus.overflow, 1'b0);
    full_frames(1);

    // Load 0xA5 pattern, send it, then underrun on the next boundary
    do_reset();
    va = {(BUF_BITS/8){8'hA5}};
    load_buffer(va);
    full_frames(FRAMES);
    full_frames(FRAMES);
    full_frames(FRAMES);

    // Overflow with extra STM bits, and a short f0 window in frame 1
    do_reset();
    va = rand_buf();
    load_buffer(va);
    full_frames(FRAMES);
    vb = rand_buf();
    load_buffer(vb);
    extra_bits(3);
    chk("overflow_after_extra", bus.overflow, m_over);
    full_frames(1);
    window(20, 1'b0);
    full_frames(FRAMES - 1);
    full_frames(FRAMES);

    // STM edge coincident with the buffer swap
    do_reset();
    va = rand_buf();
    load_buffer(va);
    full_frames(FRAMES - 1);
    window(2*SLOT_BITS + 1, 1'b1);
    chk("collision_overflow", bus.overflow, m_over);
    chk("collision_tx_req", bus.tx_req, m_tx_req);
    vb = rand_buf();
    load_buffer(vb);
    full_frames(FRAMES);
    full_frames(FRAMES);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
